// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared BCD decoder, per-slot guard interval, frame-synchronous double buffering.
module seven_seg_scan_ctrl #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                lzb,
   input  logic                load,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [3:0]          bcd,
   output logic [DIGITS-1:0]   an_n,
   output logic                frame_done,
   output logic                load_ack
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(DIGITS);
   localparam int unsigned BW = 4 * DIGITS;

   typedef enum logic {GUARD_S, SHOW_S} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [BW-1:0]   disp, disp_nxt, pend, pend_nxt;
   logic            pend_v, pend_v_nxt;
   logic [3:0]      bcd_nxt;
   logic [DIGITS-1:0] an_n_nxt;
   logic            frame_done_nxt, load_ack_nxt;
   logic            boundary, blank;
   logic [3:0]      code;

   // Digit k is dark if its code is not decimal, or if it is a leading zero under lzb.
   function automatic logic is_blank(input logic [BW-1:0] d, input logic [IW-1:0] k,
                                     input logic lz);
      logic       upper_zero;
      logic [3:0] c;
      upper_zero = 1'b1;
      c = d[4*k +: 4];
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (j >= 32'(k) && d[4*j +: 4] != 4'd0) upper_zero = 1'b0;
      end
      return (c > 4'd9) || (lz && k != '0 && upper_zero);
   endfunction

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      idx_nxt        = idx;
      disp_nxt       = disp;
      pend_nxt       = pend;
      pend_v_nxt     = pend_v;
      frame_done_nxt = 1'b0;
      load_ack_nxt   = 1'b0;
      boundary       = 1'b0;
      if (!en) begin
         state_nxt = GUARD_S;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         if (load) begin
            disp_nxt     = bcd_in;
            pend_v_nxt   = 1'b0;
            load_ack_nxt = 1'b1;
         end
      end else begin
         cnt_nxt = (cnt == CW'(REFRESH_DIV - 1)) ? '0 : cnt + 1'b1;
         case (state)
            GUARD_S: if (cnt == CW'(GUARD - 1)) state_nxt = SHOW_S;
            SHOW_S: begin
               if (cnt == CW'(REFRESH_DIV - 1)) begin
                  state_nxt = GUARD_S;
                  boundary  = (idx == IW'(DIGITS - 1));
                  idx_nxt   = boundary ? '0 : idx + 1'b1;
               end
            end
            default: state_nxt = GUARD_S;
         endcase
         // Commit happens before the new load lands, so a boundary-cycle load waits a frame.
         if (boundary) begin
            frame_done_nxt = 1'b1;
            if (pend_v) begin
               disp_nxt     = pend;
               pend_v_nxt   = 1'b0;
               load_ack_nxt = 1'b1;
            end
         end
         if (load) begin
            pend_nxt   = bcd_in;
            pend_v_nxt = 1'b1;
         end
      end
      // Outputs follow the post-edge state so they line up with the slot they describe.
      code     = disp_nxt[4*idx_nxt +: 4];
      blank    = is_blank(disp_nxt, idx_nxt, lzb);
      bcd_nxt  = (en && !blank) ? code : 4'd0;
      an_n_nxt = '1;
      if (en && state_nxt == SHOW_S && !blank) an_n_nxt[idx_nxt] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= GUARD_S;
         cnt        <= '0;
         idx        <= '0;
         disp       <= '0;
         pend       <= '0;
         pend_v     <= 1'b0;
         bcd        <= 4'd0;
         an_n       <= '1;
         frame_done <= 1'b0;
         load_ack   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         disp       <= disp_nxt;
         pend       <= pend_nxt;
         pend_v     <= pend_v_nxt;
         bcd        <= bcd_nxt;
         an_n       <= an_n_nxt;
         frame_done <= frame_done_nxt;
         load_ack   <= load_ack_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position reference model checked every cycle,
// plus literal per-slot frame patterns and reset/enable corner cases.
module tb_seven_seg_scan_ctrl;
   localparam int D  = 4;
   localparam int RD = 8;
   localparam int G  = 2;
   localparam int F  = D * RD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        lzb = 1'b0;
   logic        load = 1'b0;
   logic [15:0] bcd_in = 16'h0;
   logic [3:0]  bcd;
   logic [3:0]  an_n;
   logic        frame_done, load_ack;

   int n_cmp = 0;
   int n_bad = 0;

   seven_seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb), .load(load), .bcd_in(bcd_in),
      .bcd(bcd), .an_n(an_n), .frame_done(frame_done), .load_ack(load_ack)
   );

   always #5 clk = ~clk;

   // Reference model: position within the frame plus the display/pending words.
   int          pos = 0;
   bit          m_en = 1'b0;
   bit          m_lzb = 1'b0;
   bit          m_pv = 1'b0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_pend = 16'h0;
   bit          e_fd = 1'b0;
   bit          e_ack = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos = 0; m_en = 1'b0; m_pv = 1'b0; m_disp = 16'h0; e_fd = 1'b0; e_ack = 1'b0;
      end else if (!en) begin
         pos = 0; m_en = 1'b0; e_fd = 1'b0; e_ack = 1'b0; m_lzb = lzb;
         if (load) begin m_disp = bcd_in; m_pv = 1'b0; e_ack = 1'b1; end
      end else begin
         e_fd  = (pos == F - 1);
         e_ack = 1'b0;
         pos   = (pos + 1) % F;
         m_en  = 1'b1;
         m_lzb = lzb;
         if (e_fd && m_pv) begin m_disp = m_pend; m_pv = 1'b0; e_ack = 1'b1; end
         if (load) begin m_pend = bcd_in; m_pv = 1'b1; end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         int          digit, c;
         logic [15:0] sh;
         logic [3:0]  code, e_bcd, e_an;
         bit          blank;
         digit = pos / RD;
         c     = pos % RD;
         sh    = m_disp >> (4 * digit);
         code  = sh[3:0];
         blank = (code > 4'd9) || (m_lzb && digit > 0 && sh == 16'h0);
         e_bcd = (m_en && !blank) ? code : 4'd0;
         e_an  = (m_en && c >= G && !blank) ? ~(4'b0001 << digit) : 4'hF;
         check("model", {22'h0, an_n, bcd, frame_done, load_ack},
               {22'h0, e_an, e_bcd, e_fd, e_ack});
      end
   end

   task automatic wait_pos(input int p);
      int n = 0;
      while (!(m_en && pos == p)) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            n_bad++;
            $display("FAIL wait_pos %0d: timed out after %0d cycles", p, n);
            return;
         end
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      @(negedge clk);
      bcd_in = v; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Literal per-slot pattern: guard cycles dark with the code preset, then the slot's anode.
   task automatic check_frame(input string name, input logic [15:0] an_pat,
                              input logic [15:0] bcd_pat);
      logic [3:0] an_e, bcd_e;
      wait_pos(0);
      for (int s = 0; s < D; s++) begin
         for (int c = 0; c < RD; c++) begin
            an_e  = an_pat[4*s +: 4];
            bcd_e = bcd_pat[4*s +: 4];
            check(name, {24'h0, an_n, bcd}, {24'h0, (c < G) ? 4'hF : an_e, bcd_e});
            @(negedge clk);
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_out", {26'h0, an_n, bcd[0], frame_done, load_ack}, {26'h0, 4'hF, 3'b000});
      check("reset_bcd", {28'h0, bcd}, 32'h0);
      rst_n = 1'b1;

      // Basic scan of 1234 and coincident ack/frame_done.
      repeat (10) @(negedge clk);
      do_load(16'h1234);
      wait_pos(0);
      check("t1_fd_ack", {30'h0, frame_done, load_ack}, 32'h3);
      check_frame("t1_frame", 16'h7BDE, 16'h1234);

      // Leading-zero blanking.
      lzb = 1'b1;
      do_load(16'h0070);
      check_frame("t2_0070", 16'hFFDE, 16'h0070);
      do_load(16'h0000);
      check_frame("t2_0000", 16'hFFFE, 16'h0000);
      lzb = 1'b0;
      @(negedge clk);
      check_frame("t2_nolzb", 16'h7BDE, 16'h0000);

      // Non-decimal digit blanking.
      do_load(16'h12A4);
      check_frame("t3_12a4", 16'h7BFE, 16'h1204);

      // Overwritten pending data and a load on the boundary edge.
      do_load(16'h1111);
      do_load(16'h2222);
      check_frame("t4_2222", 16'h7BDE, 16'h2222);
      wait_pos(20);
      do_load(16'h3333);
      wait_pos(31);
      bcd_in = 16'h5555; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("t4_ack3333", {31'h0, load_ack}, 32'h1);
      check_frame("t4_3333", 16'h7BDE, 16'h3333);
      check("t4_ack5555", {31'h0, load_ack}, 32'h1);
      check_frame("t4_5555", 16'h7BDE, 16'h5555);

      // Asynchronous reset mid-slot.
      wait_pos(21);
      #2 rst_n = 1'b0;
      #1 check("t5_async", {24'h0, an_n, bcd}, {24'h0, 4'hF, 4'h0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_restart", {24'h0, an_n, bcd}, {24'h0, 4'hE, 4'h0});
      check_frame("t5_zero", 16'h7BDE, 16'h0000);

      // Disable mid-show, direct load, re-enable.
      wait_pos(12);
      en = 1'b0;
      @(negedge clk);
      check("t6_dark", {28'h0, an_n}, {28'h0, 4'hF});
      bcd_in = 16'h9876; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("t6_ack", {31'h0, load_ack}, 32'h1);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      check("t6_guard", {24'h0, an_n, bcd}, {24'h0, 4'hF, 4'h6});
      @(negedge clk);
      check("t6_show", {24'h0, an_n, bcd}, {24'h0, 4'hE, 4'h6});

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 19) == 0);
         if (load) begin
            if ($urandom_range(0, 1) == 0) bcd_in = 16'($urandom);
            else for (int k = 0; k < D; k++)
               bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 49) == 0) lzb = ~lzb;
         if ($urandom_range(0, 149) == 0) en = ~en;
         else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      end
      load = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
